// File: rtl/blit_engine.sv
// blit_engine: copies a 160x120 background or a 16x16 sprite tile from the
// selected ROM into the frame buffer, one pixel per clock. It supports a
// black override and skipping of key-coloured (transparent) pixels.
module blit_engine #(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         TILE      = 16,
    parameter logic [2:0] KEY_COLOR = 3'b101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        copy_enable,
    input  logic        full_screen,
    input  logic [1:0]  memory_select,
    input  logic [4:0]  src_index,
    input  logic [7:0]  dst_x,
    input  logic [6:0]  dst_y,
    input  logic        black,
    input  logic        skip_key,
    output logic [1:0]  rom_sel,
    output logic [14:0] rom_addr,
    input  logic [2:0]  rom_data,
    output logic [7:0]  buf_x,
    output logic [6:0]  buf_y,
    output logic [2:0]  buf_color,
    output logic        buf_we,
    output logic        finished
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    // Copy parameters, frozen when the copy starts
    logic       fs_q, black_q, skip_q;
    logic [4:0] idx_q;
    logic [7:0] dx_q;
    logic [6:0] dy_q;

    // Coordinates of the pixel whose address is currently on rom_addr
    logic [7:0] cx;
    logic [6:0] cy;

    // Issue stage (aligned with rom_addr) and write stage (aligned with rom_data)
    logic       s_vld, s_clip, w_vld, w_clip;
    logic [7:0] s_x;
    logic [6:0] s_y;

    // Next pixel to issue, and its address/destination
    logic       start, last_px, issue;
    logic       fs_m;
    logic [4:0] idx_m;
    logic [7:0] dx_m, ix, xmax;
    logic [6:0] dy_m, iy, ymax;
    logic [14:0] addr_nx;
    logic [8:0]  sx9;
    logic [7:0]  sy8;
    logic        clip_nx;

    assign start   = (state == IDLE) && copy_enable;
    assign xmax    = fs_q ? 8'(SCREEN_W - 1) : 8'(TILE - 1);
    assign ymax    = fs_q ? 7'(SCREEN_H - 1) : 7'(TILE - 1);
    assign last_px = (cx == xmax) && (cy == ymax);
    assign issue   = start || ((state == RUN) && copy_enable && !last_px);

    // Pick the first pixel on start (using live inputs), else step in raster order
    always_comb begin
        fs_m  = fs_q;
        idx_m = idx_q;
        dx_m  = dx_q;
        dy_m  = dy_q;
        ix    = cx + 8'd1;
        iy    = cy;
        if (state == IDLE) begin
            fs_m  = full_screen;
            idx_m = src_index;
            dx_m  = dst_x;
            dy_m  = dst_y;
            ix    = '0;
            iy    = '0;
        end else if (cx == xmax) begin
            ix = '0;
            iy = cy + 7'd1;
        end
        if (fs_m) begin
            addr_nx = 15'(iy) * 15'(SCREEN_W) + 15'(ix);
            sx9     = {1'b0, ix};
            sy8     = {1'b0, iy};
        end else begin
            addr_nx = 15'(idx_m) * 15'(TILE * TILE) + 15'(iy) * 15'(TILE) + 15'(ix);
            sx9     = {1'b0, dx_m} + {1'b0, ix};
            sy8     = {1'b0, dy_m} + {1'b0, iy};
        end
        clip_nx = (sx9 >= 9'(SCREEN_W)) || (sy8 >= 8'(SCREEN_H));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: dropping copy_enable mid-run aborts; DONE always lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (copy_enable) state_nx = RUN;
            RUN: begin
                if (!copy_enable)  state_nx = IDLE;
                else if (last_px)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch copy parameters, issue addresses and advance the write pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            fs_q <= 1'b0; black_q <= 1'b0; skip_q <= 1'b0;
            idx_q <= '0; dx_q <= '0; dy_q <= '0;
            rom_sel <= '0; rom_addr <= '0;
            cx <= '0; cy <= '0;
            s_vld <= 1'b0; s_clip <= 1'b0; s_x <= '0; s_y <= '0;
            w_vld <= 1'b0; w_clip <= 1'b0; buf_x <= '0; buf_y <= '0;
        end else begin
            if (start) begin
                fs_q    <= full_screen;
                black_q <= black;
                skip_q  <= skip_key;
                idx_q   <= src_index;
                dx_q    <= dst_x;
                dy_q    <= dst_y;
                rom_sel <= memory_select;
            end
            s_vld <= issue;
            if (issue) begin
                cx       <= ix;
                cy       <= iy;
                rom_addr <= addr_nx;
                s_x      <= sx9[7:0];
                s_y      <= sy8[6:0];
                s_clip   <= clip_nx;
            end
            // An abort discards the pixel still waiting for its ROM data
            w_vld  <= s_vld && !((state == RUN) && !copy_enable);
            w_clip <= s_clip;
            buf_x  <= s_x;
            buf_y  <= s_y;
        end
    end

    assign buf_we    = w_vld && !w_clip && !(skip_q && (rom_data == KEY_COLOR) && !black_q);
    assign buf_color = (w_vld && !black_q) ? rom_data : 3'd0;
    assign finished  = (state == DONE);

endmodule

// File: tb/tb_blit_engine.sv
// Self-checking bench for blit_engine: random ROM contents, reference write
// lists computed from the copy rules, directed and randomized scenarios.
module tb_blit_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        copy_enable, full_screen, black, skip_key;
    logic [1:0]  memory_select;
    logic [4:0]  src_index;
    logic [7:0]  dst_x;
    logic [6:0]  dst_y;
    logic [1:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  buf_x;
    logic [6:0]  buf_y;
    logic [2:0]  buf_color;
    logic        buf_we, finished;

    blit_engine dut (
        .clock(clock), .reset(reset), .copy_enable(copy_enable),
        .full_screen(full_screen), .memory_select(memory_select),
        .src_index(src_index), .dst_x(dst_x), .dst_y(dst_y),
        .black(black), .skip_key(skip_key), .rom_sel(rom_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .buf_x(buf_x),
        .buf_y(buf_y), .buf_color(buf_color), .buf_we(buf_we),
        .finished(finished)
    );

    always #5 clock = ~clock;

    // ROM model: one cycle read latency
    logic [2:0] rom_mem [4][32768];
    always @(posedge clock) rom_data <= rom_mem[rom_sel][rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [14:0] first_addr, last_addr, exp_first, exp_last;
    int          fin_cnt, fin_cyc, last_we_cyc, sel_bad;

    // Reference: list of expected writes {x, y, colour} in raster order
    task automatic model_copy(input bit fs, input logic [1:0] sel, input logic [4:0] idx,
                              input logic [7:0] dx, input logic [6:0] dy,
                              input bit blk, input bit skp);
        int w, h, x, y, xo, yo;
        logic [14:0] a;
        logic [2:0]  d;
        exp_q.delete();
        w = fs ? 160 : 16;
        h = fs ? 120 : 16;
        for (int k = 0; k < w * h; k++) begin
            xo = k % w;
            yo = k / w;
            a  = fs ? 15'(yo * 160 + xo) : 15'(idx * 256 + yo * 16 + xo);
            if (k == 0) exp_first = a;
            exp_last = a;
            x = fs ? xo : dx + xo;
            y = fs ? yo : dy + yo;
            d = rom_mem[sel][a];
            if (x < 160 && y < 120 && !(skp && d == 3'b101 && !blk))
                exp_q.push_back({x[7:0], y[6:0], blk ? 3'b000 : d});
        end
    endtask

    function automatic int diff_count();
        int n;
        n = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic scramble_inputs();
        full_screen   = 1'($urandom);
        memory_select = 2'($urandom);
        src_index     = 5'($urandom);
        dst_x         = 8'($urandom);
        dst_y         = 7'($urandom);
        black         = 1'($urandom);
        skip_key      = 1'($urandom);
    endtask

    // Run one copy with copy_enable held until the expected DONE cycle; records results
    task automatic run_copy(input bit fs, input logic [1:0] sel, input logic [4:0] idx,
                            input logic [7:0] dx, input logic [6:0] dy,
                            input bit blk, input bit skp);
        int n;
        @(negedge clock);
        full_screen = fs; memory_select = sel; src_index = idx;
        dst_x = dx; dst_y = dy; black = blk; skip_key = skp;
        copy_enable = 1'b1;
        n = fs ? 19200 : 256;
        got_q.delete();
        fin_cnt = 0; fin_cyc = -1; last_we_cyc = -1; sel_bad = 0;
        for (int c = 1; c <= n + 8; c++) begin
            @(negedge clock);
            if (c == 1) begin
                first_addr = rom_addr;
                scramble_inputs();
            end
            if (c == n) last_addr = rom_addr;
            if (rom_sel !== sel) sel_bad++;
            if (buf_we === 1'b1) begin
                got_q.push_back({buf_x, buf_y, buf_color});
                last_we_cyc = c;
            end
            if (finished === 1'b1) begin
                fin_cnt++;
                fin_cyc = c;
            end
            if (c == n + 1) copy_enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; copy_enable = 1'b0;
        full_screen = 0; memory_select = 0; src_index = 0; dst_x = 0; dst_y = 0;
        black = 0; skip_key = 0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished});
        end
        copy_enable = 1'b1;
        scramble_inputs();
        repeat (2) @(negedge clock);
        n_checks++;
        if ({rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished} !== '0) begin
            n_fail++;
            $display("FAIL reset_priority: got %h required 0",
                     {rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished});
        end
        copy_enable = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_tile();
        run_copy(0, 2'd3, 5'd3, 8'd32, 7'd48, 0, 0);
        model_copy(0, 2'd3, 5'd3, 8'd32, 7'd48, 0, 0);
        n_checks++;
        if (first_addr !== 15'd768) begin n_fail++; $display("FAIL tile_first_addr: got %0d required 768", first_addr); end
        n_checks++;
        if (last_addr !== 15'd1023) begin n_fail++; $display("FAIL tile_last_addr: got %0d required 1023", last_addr); end
        n_checks++;
        if (fin_cnt !== 1 || fin_cyc !== 257) begin n_fail++; $display("FAIL tile_finished: got %0d pulses at %0d required 1 at 257", fin_cnt, fin_cyc); end
        n_checks++;
        if (got_q.size() !== 256) begin n_fail++; $display("FAIL tile_write_count: got %0d required 256", got_q.size()); end
        n_checks++;
        if (diff_count() !== 0) begin n_fail++; $display("FAIL tile_writes: %0d differing writes required 0", diff_count()); end
        n_checks++;
        if (last_we_cyc !== 257) begin n_fail++; $display("FAIL tile_last_write_cycle: got %0d required 257", last_we_cyc); end
        n_checks++;
        if (sel_bad !== 0) begin n_fail++; $display("FAIL tile_rom_sel: %0d bad cycles required 0", sel_bad); end
    endtask

    task automatic test_full_screen();
        run_copy(1, 2'd1, 5'($urandom), 8'($urandom), 7'($urandom), 0, 0);
        model_copy(1, 2'd1, 5'd0, 8'd0, 7'd0, 0, 0);
        n_checks++;
        if (got_q.size() !== 19200) begin n_fail++; $display("FAIL fs_write_count: got %0d required 19200", got_q.size()); end
        n_checks++;
        if (got_q.size() == 0 || got_q[$] !== {8'd159, 7'd119, rom_mem[1][19199]}) begin
            n_fail++; $display("FAIL fs_last_write: got %h required %h",
                               (got_q.size() == 0) ? 18'h0 : got_q[$], {8'd159, 7'd119, rom_mem[1][19199]});
        end
        n_checks++;
        if (fin_cnt !== 1 || fin_cyc !== 19201 || last_we_cyc !== 19201) begin
            n_fail++; $display("FAIL fs_finished: got %0d pulses at %0d last write %0d required 1 at 19201",
                               fin_cnt, fin_cyc, last_we_cyc);
        end
        n_checks++;
        if (last_addr !== 15'd19199) begin n_fail++; $display("FAIL fs_last_addr: got %0d required 19199", last_addr); end
        n_checks++;
        if (sel_bad !== 0) begin n_fail++; $display("FAIL fs_rom_sel: %0d bad cycles required 0", sel_bad); end
        n_checks++;
        if (diff_count() !== 0) begin n_fail++; $display("FAIL fs_writes: %0d differing writes required 0", diff_count()); end
    endtask

    task automatic test_clip_skip();
        logic [4:0] idx;
        int keys;
        idx = 5'($urandom);
        run_copy(0, 2'd3, idx, 8'd152, 7'd112, 0, 0);
        model_copy(0, 2'd3, idx, 8'd152, 7'd112, 0, 0);
        n_checks++;
        if (got_q.size() !== 64) begin n_fail++; $display("FAIL clip_count: got %0d required 64", got_q.size()); end
        n_checks++;
        if (fin_cnt !== 1 || fin_cyc !== 257) begin n_fail++; $display("FAIL clip_finished: got %0d pulses at %0d required 1 at 257", fin_cnt, fin_cyc); end
        n_checks++;
        if (diff_count() !== 0) begin n_fail++; $display("FAIL clip_writes: %0d differing writes required 0", diff_count()); end
        run_copy(0, 2'd3, idx, 8'd40, 7'd20, 0, 1);
        model_copy(0, 2'd3, idx, 8'd40, 7'd20, 0, 1);
        keys = 0;
        foreach (got_q[i]) if (got_q[i][2:0] == 3'b101) keys++;
        n_checks++;
        if (keys !== 0) begin n_fail++; $display("FAIL skip_key_written: got %0d key writes required 0", keys); end
        n_checks++;
        if (diff_count() !== 0) begin n_fail++; $display("FAIL skip_writes: %0d differing writes required 0", diff_count()); end
    endtask

    task automatic test_black();
        int nz;
        run_copy(0, 2'($urandom), 5'($urandom), 8'd64, 7'd64, 1, 1);
        nz = 0;
        foreach (got_q[i]) if (got_q[i][2:0] != 3'd0) nz++;
        n_checks++;
        if (got_q.size() !== 256) begin n_fail++; $display("FAIL black_count: got %0d required 256", got_q.size()); end
        n_checks++;
        if (nz !== 0) begin n_fail++; $display("FAIL black_color: got %0d nonzero colours required 0", nz); end
    endtask

    task automatic test_random_tiles();
        logic [1:0] sel; logic [4:0] idx; logic [7:0] dx; logic [6:0] dy; bit blk, skp;
        for (int t = 0; t < 6; t++) begin
            sel = 2'($urandom); idx = 5'($urandom); dx = 8'($urandom); dy = 7'($urandom);
            blk = 1'($urandom); skp = 1'($urandom);
            run_copy(0, sel, idx, dx, dy, blk, skp);
            model_copy(0, sel, idx, dx, dy, blk, skp);
            n_checks++;
            if (diff_count() !== 0 || fin_cnt !== 1 || fin_cyc !== 257) begin
                n_fail++;
                $display("FAIL random_tile_%0d: %0d differing writes, %0d pulses at %0d required 0, 1 at 257",
                         t, diff_count(), fin_cnt, fin_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a, b;
        logic [17:0] got1[$], got2[$];
        int fins[$];
        int bad1, bad2;
        a = 5'($urandom);
        b = a ^ 5'(1 + $urandom_range(0, 30));
        @(negedge clock);
        full_screen = 0; memory_select = 2'd3; src_index = a; dst_x = 8'd16; dst_y = 7'd16;
        black = 0; skip_key = 0; copy_enable = 1'b1;
        for (int c = 1; c <= 530; c++) begin
            @(negedge clock);
            if (c == 1) src_index = b;
            if (buf_we === 1'b1) begin
                if (c <= 257) got1.push_back({buf_x, buf_y, buf_color});
                else          got2.push_back({buf_x, buf_y, buf_color});
            end
            if (finished === 1'b1) fins.push_back(c);
            if (c == 515) copy_enable = 1'b0;
        end
        n_checks++;
        if (fins.size() !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d required 2", fins.size()); end
        else begin
            n_checks++;
            if (fins[0] !== 257 || fins[1] - fins[0] !== 258) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d and %0d required 257 and 515", fins[0], fins[1]);
            end
        end
        model_copy(0, 2'd3, a, 8'd16, 7'd16, 0, 0);
        bad1 = (got1.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got1.size() && i < exp_q.size(); i++) if (got1[i] !== exp_q[i]) bad1++;
        model_copy(0, 2'd3, b, 8'd16, 7'd16, 0, 0);
        bad2 = (got2.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got2.size() && i < exp_q.size(); i++) if (got2[i] !== exp_q[i]) bad2++;
        n_checks++;
        if (bad1 !== 0) begin n_fail++; $display("FAIL b2b_first_copy: %0d differing writes required 0", bad1); end
        n_checks++;
        if (bad2 !== 0) begin n_fail++; $display("FAIL b2b_second_copy: %0d differing writes required 0", bad2); end
    endtask

    // mode 0: drop copy_enable at pixel 100; mode 1: assert reset there instead
    task automatic test_abort(input bit use_reset);
        int early, late, fin;
        @(negedge clock);
        full_screen = 0; memory_select = 2'd2; src_index = 5'($urandom);
        dst_x = 8'd8; dst_y = 7'd8; black = 0; skip_key = 0; copy_enable = 1'b1;
        early = 0; late = 0; fin = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clock);
            if (buf_we === 1'b1) begin
                if (c <= 101) early++;
                else          late++;
            end
            if (finished === 1'b1) fin++;
            if (use_reset && c == 102) begin
                n_checks++;
                if ({rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished} !== '0) begin
                    n_fail++; $display("FAIL reset_mid_outputs: got %h required 0",
                                       {rom_sel, rom_addr, buf_x, buf_y, buf_color, buf_we, finished});
                end
                reset = 1'b0;
            end
            if (c == 101) begin
                copy_enable = 1'b0;
                if (use_reset) reset = 1'b1;
            end
        end
        n_checks++;
        if (early !== 100) begin n_fail++; $display("FAIL abort_%0d_early_writes: got %0d required 100", use_reset, early); end
        n_checks++;
        if (late !== 0 || fin !== 0) begin
            n_fail++; $display("FAIL abort_%0d_after: got %0d writes %0d finished required 0 0", use_reset, late, fin);
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 32768; a++)
                rom_mem[s][a] = 3'($urandom);
        test_reset();
        test_tile();
        test_clip_skip();
        test_black();
        test_random_tiles();
        test_back_to_back();
        test_abort(0);
        test_abort(1);
        test_tile();
        test_full_screen();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
